instruction_prefetcher: RTL and testbench
=========================================

Name: instruction_prefetcher

Overview:
- Prefetch stage directly upstream of the instruction decoder.
- Issues word-address fetch requests to the byte-serial memory interface and assembles 16-bit instruction words from low/high byte pairs.
- Buffers assembled words, tagged with their address, in a small queue that feeds the decoder over a valid/ready handshake.
- On a decoder-requested jump: flushes the queue, redirects fetch, and drops stale in-flight responses.

Parameters:
- DEPTH, 3: queue entries (2..4).
- ADDR_BITS, 16: word-address width.
- MAX_OUTSTANDING, 2: maximum requests accepted but not fully answered.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- jump  in  1  decoder redirect strobe, single cycle.
- jump_addr  in  ADDR_BITS  redirect target word address.
- mem_req_valid  out  1  fetch request valid.
- mem_req_ready  in  1  memory accepts the request.
- mem_req_addr  out  ADDR_BITS  word address of the request.
- mem_resp_valid  in  1  response byte valid.
- mem_resp_data  in  8  response byte; low byte first, then high byte, in request order.
- inst_valid  out  1  queue head valid.
- inst_data  out  16  head instruction word.
- inst_pc  out  ADDR_BITS  head word address.
- inst_ready  in  1  decoder consumes the head.

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-high, named reset. On reset: fetch_pc=0, queue empty, outstanding=0, stale=0, byte phase=0, mem_req_valid=0, inst_valid=0, inst_data=0, inst_pc=0.
- Request issue:
  - mem_req_valid=1 iff count+outstanding<DEPTH, outstanding<MAX_OUTSTANDING and jump=0.
  - mem_req_addr=fetch_pc.
  - Accept (valid&ready): fetch_pc+=1, wrapping modulo 2^ADDR_BITS; outstanding+=1.
  - valid/addr change only after acceptance, or by dropping valid on a jump cycle.
- Response assembly:
  - Phase 0 byte: latched as the low byte; phase becomes 1.
  - Phase 1 byte: completes the word {resp,low}; phase becomes 0; outstanding-=1.
  - A completed word is pushed with tag word_pc, and word_pc+=1 (wrapping). If stale>0, the word is dropped instead and stale-=1.
  - The credit rule guarantees a push never overflows the queue.
- Queue:
  - FIFO; head driven onto inst_*.
  - Pop on inst_valid&inst_ready.
  - Push and pop may occur in the same cycle at any count, including full.
- Jump (cycle J):
  - Queue cleared after any same-cycle pop completes (that pop counts as consumed).
  - fetch_pc=word_pc=jump_addr.
  - stale=outstanding, minus 1 if a word completes in cycle J; that completing word is dropped.
  - No request is issued in cycle J.
  - Byte phase is not reset: partial words still arrive physically and are discarded by the stale count.
  - The first request to jump_addr is issued at J+1 if credit allows.
- Latency:
  - Request accepted at cycle T.
  - Earliest high byte at T+2.
  - inst_valid at the following cycle (T+3).
- Memory side must be reset together with this block; bytes from requests issued before reset are not tolerated.

Optional Feature:
- Macro: PREFETCH_BYPASS_EN.
- Defined: when the queue is empty (or will be emptied by a same-cycle pop of its only entry) and a non-stale word completes, the word is presented combinationally on inst_* in the same cycle. If inst_ready=1, it is consumed without being written; otherwise it is written into the queue.
- Undefined: inst_valid rises one cycle after the completing high byte.

Decomposition:
- Shared package/header holds:
  - INST_BITS=16 and ADDR_BITS.
  - Queue entry typedef {pc, data}.
  - MEM_BYTE_BITS=8.
- Sub-module prefetch_fifo (instance name fifo): DEPTH-entry register queue with push/pop/flush and count output.
- Everything else (credit logic, byte assembly, stale counter) lives in instruction_prefetcher.

Test Plan:
- Reset, then memory returns word at addr N as bytes {N[7:0]^8'hA5, 8'h12}, 1-cycle latency, inst_ready=1 → inst_pc sequence 0,1,2,3…; inst_data for pc 2 = 16'h12A7; at most MAX_OUTSTANDING requests open.
- inst_ready=0 → exactly 3 requests (addr 0,1,2), mem_req_valid stays 0; one inst_ready pulse → addr 3 requested next cycle.
- Two outstanding requests with low byte of the first already received; assert jump, jump_addr=16'h0100 → both in-flight words dropped; next inst_pc=16'h0100, first request addr 16'h0100 issued the cycle after the jump.
- Jump in the same cycle as a completing high byte and an inst_ready pop → completing word not queued; popped word counted once; stale=outstanding-1.
- fetch_pc=16'hFFFF → following request addr 16'h0000; inst_pc wraps identically.
- Reset asserted mid-response → all outputs 0 immediately, asynchronously; after release, first request addr 0.

Source files
------------

// File: rtl/instruction_prefetcher_pkg.sv
// Shared widths and the queue entry type for the instruction prefetcher.
package instruction_prefetcher_pkg;

  localparam int INST_BITS     = 16;
  localparam int ADDR_BITS     = 16;
  localparam int MEM_BYTE_BITS = 8;

  // One buffered instruction word tagged with its word address.
  typedef struct packed {
    logic [ADDR_BITS-1:0] pc;
    logic [INST_BITS-1:0] data;
  } inst_entry_t;

endpackage

// File: rtl/instruction_prefetcher_fifo.sv
// prefetch_fifo: DEPTH-entry register queue with push, pop, flush and an
// occupancy count. Push and pop may coincide at any count, including full;
// flush wins over both and leaves the queue empty.
module prefetch_fifo
  import instruction_prefetcher_pkg::*;
#(
  parameter int  DEPTH   = 3,
  parameter type entry_t = inst_entry_t,
  localparam int CW      = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  entry_t        push_entry,
  input  logic          pop,
  input  logic          flush,
  output entry_t        head,
  output logic [CW-1:0] count
);

  localparam int PW = $clog2(DEPTH);

  entry_t          mem_q [DEPTH];
  entry_t          mem_d [DEPTH];
  logic [PW-1:0]   rd_q, rd_d;
  logic [PW-1:0]   wr_q, wr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            do_pop;

  // Pointer increment that wraps at DEPTH (DEPTH need not be a power of two).
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (int'(p) == DEPTH - 1) ? '0 : p + PW'(1);
  endfunction

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d   = mem_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    count_d = count_q;
    do_pop  = pop && (count_q != '0);
    if (push) begin
      mem_d[wr_q] = push_entry;
      wr_d        = ptr_inc(wr_q);
    end
    if (do_pop) begin
      rd_d = ptr_inc(rd_q);
    end
    count_d = count_q + CW'(push) - CW'(do_pop);
    if (flush) begin
      rd_d    = '0;
      wr_d    = '0;
      count_d = '0;
    end
  end

  // Queue state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      count_q <= count_d;
    end
  end

  assign head  = mem_q[rd_q];
  assign count = count_q;

endmodule

// File: rtl/instruction_prefetcher.sv
// instruction_prefetcher: issues word fetches to a byte-serial memory,
// assembles low/high byte pairs into 16-bit words and queues them, tagged
// with their address, for the decoder (valid/ready: a word moves when
// inst_valid and inst_ready are both high in the same cycle; the request
// side likewise moves on mem_req_valid & mem_req_ready).
// A request is only issued when queue slots cover every outstanding word,
// so a completed word can always be pushed.
// Optional build macro PREFETCH_BYPASS_EN: a word completing into an empty
// queue is shown on inst_* in the same cycle.
module instruction_prefetcher #(
  parameter int DEPTH           = 3,
  parameter int ADDR_BITS       = instruction_prefetcher_pkg::ADDR_BITS,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                                                clk,
  input  logic                                                reset,
  input  logic                                                jump,
  input  logic [ADDR_BITS-1:0]                                jump_addr,
  output logic                                                mem_req_valid,
  input  logic                                                mem_req_ready,
  output logic [ADDR_BITS-1:0]                                mem_req_addr,
  input  logic                                                mem_resp_valid,
  input  logic [instruction_prefetcher_pkg::MEM_BYTE_BITS-1:0] mem_resp_data,
  output logic                                                inst_valid,
  output logic [instruction_prefetcher_pkg::INST_BITS-1:0]     inst_data,
  output logic [ADDR_BITS-1:0]                                inst_pc,
  input  logic                                                inst_ready
);

  import instruction_prefetcher_pkg::*;

  localparam int CW = $clog2(DEPTH + 1);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);

  // Entry type sized by this instance's address width.
  typedef struct packed {
    logic [ADDR_BITS-1:0] pc;
    logic [INST_BITS-1:0] data;
  } entry_t;

  logic [ADDR_BITS-1:0]     fetch_pc_q, fetch_pc_d;
  logic [ADDR_BITS-1:0]     word_pc_q, word_pc_d;
  logic [OW-1:0]            outstanding_q, outstanding_d;
  logic [OW-1:0]            stale_q, stale_d;
  logic                     phase_q, phase_d;
  logic [MEM_BYTE_BITS-1:0] low_q, low_d;

  logic          accept, complete, word_push, head_valid;
  logic          fifo_push, fifo_pop;
  entry_t        new_entry, fifo_head, head_sel;
  logic [CW-1:0] fifo_count;

  // Request credit, byte completion and decoder-facing head selection.
  always_comb begin
    mem_req_valid = ((int'(fifo_count) + int'(outstanding_q)) < DEPTH) &&
                    (int'(outstanding_q) < MAX_OUTSTANDING) && !jump && !reset;
    mem_req_addr  = fetch_pc_q;
    accept        = mem_req_valid && mem_req_ready;
    complete      = mem_resp_valid && phase_q;
    // A word completing on a jump cycle or while stale words remain is discarded.
    word_push     = complete && !jump && (stale_q == '0);
    new_entry     = '{pc: word_pc_q, data: {mem_resp_data, low_q}};
    head_valid    = (fifo_count != '0);
    fifo_pop      = head_valid && inst_ready;
`ifdef PREFETCH_BYPASS_EN
    inst_valid    = head_valid || word_push;
    head_sel      = head_valid ? fifo_head : new_entry;
    fifo_push     = word_push && !(!head_valid && inst_ready);
`else
    inst_valid    = head_valid;
    head_sel      = fifo_head;
    fifo_push     = word_push;
`endif
    inst_data     = inst_valid ? head_sel.data : '0;
    inst_pc       = inst_valid ? head_sel.pc : '0;
  end

  // Next-state for fetch/word pointers, credit, stale count and byte phase.
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    word_pc_d     = word_pc_q;
    outstanding_d = outstanding_q + OW'(accept) - OW'(complete);
    stale_d       = stale_q;
    phase_d       = phase_q;
    low_d         = low_q;
    if (mem_resp_valid) begin
      if (!phase_q) begin
        low_d   = mem_resp_data;
        phase_d = 1'b1;
      end else begin
        phase_d = 1'b0;
      end
    end
    if (jump) begin
      // Every word still owed by memory becomes stale; the one completing now
      // is dropped directly. The byte phase carries on untouched.
      fetch_pc_d = jump_addr;
      word_pc_d  = jump_addr;
      stale_d    = outstanding_q - OW'(complete);
    end else begin
      if (accept) begin
        fetch_pc_d = fetch_pc_q + ADDR_BITS'(1);
      end
      if (word_push) begin
        word_pc_d = word_pc_q + ADDR_BITS'(1);
      end
      if (complete && (stale_q != '0)) begin
        stale_d = stale_q - OW'(1);
      end
    end
  end

  // Control state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_q    <= '0;
      word_pc_q     <= '0;
      outstanding_q <= '0;
      stale_q       <= '0;
      phase_q       <= 1'b0;
      low_q         <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      word_pc_q     <= word_pc_d;
      outstanding_q <= outstanding_d;
      stale_q       <= stale_d;
      phase_q       <= phase_d;
      low_q         <= low_d;
    end
  end

  prefetch_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) fifo (
    .clk        (clk),
    .rst        (reset),
    .push       (fifo_push),
    .push_entry (new_entry),
    .pop        (fifo_pop),
    .flush      (jump),
    .head       (fifo_head),
    .count      (fifo_count)
  );

endmodule

// File: tb/tb_instruction_prefetcher.sv
// Testbench for instruction_prefetcher: directed scenarios against a
// word-level model (expected instruction queue plus in-flight request list).
module tb_instruction_prefetcher;

  localparam int DEPTH   = 3;
  localparam int MAX_OUT = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        jump;
  logic [15:0] jump_addr;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [15:0] mem_req_addr;
  logic        mem_resp_valid;
  logic [7:0]  mem_resp_data;
  logic        inst_valid;
  logic [15:0] inst_data;
  logic [15:0] inst_pc;
  logic        inst_ready;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  instruction_prefetcher #(
    .DEPTH           (DEPTH),
    .ADDR_BITS       (16),
    .MAX_OUTSTANDING (MAX_OUT)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .jump           (jump),
    .jump_addr      (jump_addr),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data),
    .inst_valid     (inst_valid),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc),
    .inst_ready     (inst_ready)
  );

  // ---------------- scoreboard / model state ----------------
  int          checks = 0;
  int          errors = 0;
  int          cyc;
  int          first_valid;
  logic [31:0] exp_q[$];     // expected queued words {pc, data}
  bit          infl_q[$];    // requests owed by memory; 1 = will be discarded
  bit          m_half;       // low byte of the oldest owed word already seen
  logic [15:0] m_fetch_pc;
  logic [15:0] m_word_pc;
  logic [7:0]  bq_data[$];   // memory byte stream
  int          bq_rdy[$];
  logic [15:0] acc_q[$];     // addresses the DUT had accepted
  logic [31:0] pop_q[$];     // words the DUT handed over {pc, data}
  logic        s_req_valid;
  logic [15:0] s_req_addr;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return {8'h12, a[7:0] ^ 8'hA5};
  endfunction

  function automatic logic [31:0] pop_at(input int i);
    return (i < pop_q.size()) ? pop_q[i] : 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] acc_at(input int i);
    return (i < acc_q.size()) ? {16'h0000, acc_q[i]} : 32'hDEAD_BEEF;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    infl_q.delete();
    bq_data.delete();
    bq_rdy.delete();
    acc_q.delete();
    pop_q.delete();
    m_half      = 1'b0;
    m_fetch_pc  = 16'h0000;
    m_word_pc   = 16'h0000;
    cyc         = 0;
    first_valid = -1;
  endtask

  // Reset asserted between clock edges; outputs must clear without a clock.
  task automatic do_reset();
    @(posedge clk);
    #2;
    reset          = 1'b1;
    jump           = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_data  = 8'h00;
    inst_ready     = 1'b0;
    #1;
    check("rst_req_valid",  32'(mem_req_valid), 32'h0);
    check("rst_req_addr",   32'(mem_req_addr),  32'h0);
    check("rst_inst_valid", 32'(inst_valid),    32'h0);
    check("rst_inst_data",  32'(inst_data),     32'h0);
    check("rst_inst_pc",    32'(inst_pc),       32'h0);
    model_clear();
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // ---------------- driver + per-cycle compare ----------------
  // Called at a negedge: drive, let outputs settle, compare, advance model.
  task automatic step(input logic j, input logic [15:0] ja, input logic rdy, input logic men);
    logic        exp_rv;
    logic        exp_iv;
    logic        resp;
    logic [31:0] head;
    logic [15:0] w;
    bit          st;
    jump          = j;
    jump_addr     = ja;
    inst_ready    = rdy;
    mem_req_ready = 1'b1;
    resp = men && (bq_data.size() > 0) && (bq_rdy.size() > 0) && (bq_rdy[0] <= cyc);
    mem_resp_valid = resp;
    mem_resp_data  = resp ? bq_data[0] : 8'h00;
    if (resp) begin
      void'(bq_data.pop_front());
      void'(bq_rdy.pop_front());
    end
    #1;
    exp_rv = ((exp_q.size() + infl_q.size()) < DEPTH) && (infl_q.size() < MAX_OUT) && !j;
    exp_iv = (exp_q.size() > 0);
    head   = exp_iv ? exp_q[0] : 32'h0;
    check("mem_req_valid", 32'(mem_req_valid), 32'(exp_rv));
    check("mem_req_addr",  32'(mem_req_addr),  32'(m_fetch_pc));
    check("inst_valid",    32'(inst_valid),    32'(exp_iv));
    check("inst_pc",       32'(inst_pc),       32'(head[31:16]));
    check("inst_data",     32'(inst_data),     32'(head[15:0]));
    s_req_valid = mem_req_valid;
    s_req_addr  = mem_req_addr;
    if (inst_valid && first_valid < 0) first_valid = cyc;
    // memory answers the DUT's real requests, low byte then high byte
    if (mem_req_valid && mem_req_ready) begin
      acc_q.push_back(mem_req_addr);
      w = mem_word(mem_req_addr);
      bq_data.push_back(w[7:0]);
      bq_rdy.push_back(cyc + 1);
      bq_data.push_back(w[15:8]);
      bq_rdy.push_back(cyc + 1);
    end
    if (inst_valid && rdy) pop_q.push_back({inst_pc, inst_data});
    // model: consume, complete words, redirect, issue
    if (exp_iv && rdy) void'(exp_q.pop_front());
    if (resp) begin
      if (!m_half) begin
        m_half = 1'b1;
      end else begin
        m_half = 1'b0;
        if (infl_q.size() > 0) begin
          st = infl_q.pop_front();
          if (!st && !j) begin
            exp_q.push_back({m_word_pc, mem_word(m_word_pc)});
            m_word_pc++;
          end
        end
      end
    end
    if (j) begin
      exp_q.delete();
      foreach (infl_q[i]) infl_q[i] = 1'b1;
      m_fetch_pc = ja;
      m_word_pc  = ja;
    end
    if (exp_rv) begin
      infl_q.push_back(1'b0);
      m_fetch_pc++;
    end
    cyc++;
    @(negedge clk);
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    bit ok;
    reset          = 1'b1;
    jump           = 1'b0;
    jump_addr      = 16'h0000;
    mem_req_ready  = 1'b1;
    mem_resp_valid = 1'b0;
    mem_resp_data  = 8'h00;
    inst_ready     = 1'b0;
    do_reset();

    // streaming with decoder always ready
    repeat (20) step(1'b0, 16'h0, 1'b1, 1'b1);
    check("first_latency", 32'(first_valid), 32'd3);
    check("stream_pc0",    pop_at(0), {16'h0000, 16'h12A5});
    check("stream_pc2",    pop_at(2), {16'h0002, 16'h12A7});
    check("stream_pc5",    pop_at(5), {16'h0005, 16'h12A0});

    // decoder stalled: credit limits to three requests
    do_reset();
    repeat (12) step(1'b0, 16'h0, 1'b0, 1'b1);
    check("bp_accepts",   32'(acc_q.size()), 32'd3);
    check("bp_addr2",     acc_at(2), 32'h0000_0002);
    check("bp_req_idle",  32'(s_req_valid), 32'h0);
    step(1'b0, 16'h0, 1'b1, 1'b1);
    step(1'b0, 16'h0, 1'b0, 1'b1);
    check("bp_next_valid", 32'(s_req_valid), 32'h1);
    check("bp_next_addr",  32'(s_req_addr),  32'h0000_0003);

    // jump with two words in flight, first one half received
    do_reset();
    repeat (3) step(1'b0, 16'h0, 1'b1, 1'b0);
    step(1'b0, 16'h0, 1'b1, 1'b1);
    pop_q.delete();
    step(1'b1, 16'h0100, 1'b1, 1'b1);
    check("jmp_req_blocked", 32'(s_req_valid), 32'h0);
    step(1'b0, 16'h0, 1'b1, 1'b1);
    check("jmp_next_valid", 32'(s_req_valid), 32'h1);
    check("jmp_next_addr",  32'(s_req_addr),  32'h0000_0100);
    repeat (10) step(1'b0, 16'h0, 1'b1, 1'b1);
    check("jmp_first_entry", pop_at(0), {16'h0100, 16'h12A5});

    // jump coinciding with a completing word and a decoder pop
    do_reset();
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      step(1'b0, 16'h0, 1'b0, 1'b1);
      if (exp_q.size() == 2 && infl_q.size() == 1 && m_half) begin
        ok = 1'b1;
        break;
      end
    end
    check("pj_setup_reached", 32'(ok), 32'h1);
    pop_q.delete();
    step(1'b1, 16'h0200, 1'b1, 1'b1);
    check("pj_popped",    pop_at(0), {16'h0000, 16'h12A5});
    check("pj_pop_count", 32'(pop_q.size()), 32'd1);
    step(1'b0, 16'h0, 1'b1, 1'b1);
    check("pj_next_valid", 32'(s_req_valid), 32'h1);
    check("pj_next_addr",  32'(s_req_addr),  32'h0000_0200);
    repeat (8) step(1'b0, 16'h0, 1'b1, 1'b1);
    check("pj_after_jump", pop_at(1), {16'h0200, 16'h12A5});

    // address wrap
    do_reset();
    step(1'b1, 16'hFFFE, 1'b1, 1'b1);
    repeat (12) step(1'b0, 16'h0, 1'b1, 1'b1);
    check("wrap_acc1", acc_at(1), 32'h0000_FFFF);
    check("wrap_acc2", acc_at(2), 32'h0000_0000);
    check("wrap_pop0", pop_at(0), {16'hFFFE, 16'h125B});
    check("wrap_pop1", pop_at(1), {16'hFFFF, 16'h125A});
    check("wrap_pop2", pop_at(2), {16'h0000, 16'h12A5});

    // reset in the middle of a response stream
    repeat (3) step(1'b0, 16'h0, 1'b1, 1'b1);
    do_reset();
    step(1'b0, 16'h0, 1'b1, 1'b1);
    check("post_rst_valid", 32'(s_req_valid), 32'h1);
    check("post_rst_addr",  32'(s_req_addr),  32'h0);

    // ---------------- report ----------------
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time limit so the bench always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
